boss_hp_ctl: RTL and testbench

//  Boss-side consumer of the player weapon hit signals (melee_hit, projectile_hit).
//  - Edge-detects the hit inputs and applies damage to the boss HP register.
//  - Enforces invulnerability frames after each hit, then sequences the boss death.
//  - Drives boss_alive back to the weapon and projectile logic, plus HP/flash/death

---
 rtl/boss_hp_ctl.sv | 147 ++++++++++++++
 tb/tb_boss_hp_ctl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/boss_hp_ctl.sv
// Boss hit-point controller: turns weapon hit edges into HP damage, applies
// invulnerability frames after each hit and sequences the boss death.
module boss_hp_ctl #(
  parameter int HP_W         = 8,
  parameter int BOSS_HP_MAX  = 100,
  parameter int MELEE_DMG    = 4,
  parameter int PROJ_DMG     = 2,
  parameter int IFRAMES      = 8,
  parameter int DEATH_FRAMES = 60
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic [1:0]      game_active,
  input  logic            melee_hit,
  input  logic            projectile_hit,
  output logic            boss_alive,
  output logic [HP_W-1:0] boss_hp,
  output logic            hit_flash,
  output logic            boss_dying,
  output logic            boss_defeated
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIVE,
    S_HURT,
    S_DYING,
    S_DEAD
  } state_t;

  localparam int CNT_MAX = (IFRAMES > DEATH_FRAMES) ? IFRAMES : DEATH_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [HP_W-1:0]  HP_FULL  = HP_W'(BOSS_HP_MAX);
  localparam logic [HP_W:0]    MELEE_D  = (HP_W+1)'(MELEE_DMG);
  localparam logic [HP_W:0]    PROJ_D   = (HP_W+1)'(PROJ_DMG);
  localparam logic [CNT_W-1:0] CNT_IFR  = CNT_W'(IFRAMES);
  localparam logic [CNT_W-1:0] CNT_DTH  = CNT_W'(DEATH_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [HP_W-1:0]   hp_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              defeated_nx;
  logic              melee_q;
  logic              proj_q;
  logic              m_evt;
  logic              p_evt;
  logic              in_play;
  logic [HP_W:0]     dmg;

  assign in_play = (game_active == 2'd1);
  assign m_evt   = melee_hit & ~melee_q;
  assign p_evt   = projectile_hit & ~proj_q;
  // One extra bit so simultaneous hits can never overflow the damage sum.
  assign dmg     = (m_evt ? MELEE_D : '0) + (p_evt ? PROJ_D : '0);

  always_comb begin
    state_nx    = state;
    hp_nx       = boss_hp;
    cnt_nx      = cnt;
    defeated_nx = 1'b0;
    if (state != S_IDLE && !in_play) begin
      state_nx = S_IDLE;
      hp_nx    = HP_FULL;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          hp_nx  = HP_FULL;
          cnt_nx = '0;
          if (in_play) state_nx = S_ALIVE;
        end
        S_ALIVE: begin
          if (dmg != '0) begin
            // Lethal hits saturate at zero rather than wrapping.
            if ({1'b0, boss_hp} <= dmg) begin
              hp_nx    = '0;
              cnt_nx   = CNT_DTH;
              state_nx = S_DYING;
            end else begin
              hp_nx    = boss_hp - dmg[HP_W-1:0];
              cnt_nx   = CNT_IFR;
              state_nx = S_HURT;
            end
          end
        end
        S_HURT: begin
          if (frame_tick) begin
            cnt_nx = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) begin
              cnt_nx   = '0;
              state_nx = S_ALIVE;
            end
          end
        end
        S_DYING: begin
          if (frame_tick) begin
            cnt_nx = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) begin
              cnt_nx      = '0;
              state_nx    = S_DEAD;
              defeated_nx = 1'b1;
            end
          end
        end
        S_DEAD: begin
          hp_nx = '0;
        end
        default: begin
          state_nx = S_IDLE;
          hp_nx    = HP_FULL;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they line up with boss_hp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      boss_hp       <= HP_FULL;
      cnt           <= '0;
      melee_q       <= 1'b0;
      proj_q        <= 1'b0;
      boss_alive    <= 1'b0;
      hit_flash     <= 1'b0;
      boss_dying    <= 1'b0;
      boss_defeated <= 1'b0;
    end else begin
      state         <= state_nx;
      boss_hp       <= hp_nx;
      cnt           <= cnt_nx;
      melee_q       <= melee_hit;
      proj_q        <= projectile_hit;
      boss_alive    <= (state_nx == S_ALIVE) || (state_nx == S_HURT);
      hit_flash     <= (state_nx == S_HURT);
      boss_dying    <= (state_nx == S_DYING);
      boss_defeated <= defeated_nx;
    end
  end

endmodule

// File: tb/tb_boss_hp_ctl.sv
// Directed self-checking bench for boss_hp_ctl: damage, i-frames, death
// sequencing, aborts to idle and asynchronous reset.
module tb_boss_hp_ctl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [1:0] game_active;
  logic       melee_hit;
  logic       projectile_hit;
  logic       boss_alive;
  logic [7:0] boss_hp;
  logic       hit_flash;
  logic       boss_dying;
  logic       boss_defeated;

  int total;
  int bad;

  boss_hp_ctl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .game_active    (game_active),
    .melee_hit      (melee_hit),
    .projectile_hit (projectile_hit),
    .boss_alive     (boss_alive),
    .boss_hp        (boss_hp),
    .hit_flash      (hit_flash),
    .boss_dying     (boss_dying),
    .boss_defeated  (boss_defeated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; outputs are observed 1ns after the sampling edge.
  task automatic applyStimulus(input logic [1:0] ga, input logic m, input logic p, input logic ft);
    game_active    = ga;
    melee_hit      = m;
    projectile_hit = p;
    frame_tick     = ft;
    @(posedge clk);
    #1;
  endtask

  task automatic hitAndRecover(input logic m, input logic p);
    applyStimulus(2'd1, m, p, 1'b0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    frame_tick     = 1'b0;
    game_active    = 2'd0;
    melee_hit      = 1'b0;
    projectile_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hp", boss_hp, 100);
    checkOutput("rst_alive", boss_alive, 0);
    checkOutput("rst_flash", hit_flash, 0);
    checkOutput("rst_dying", boss_dying, 0);
    checkOutput("rst_defeated", boss_defeated, 0);
    #2 rst = 1'b0;

    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_alive", boss_alive, 1);
    checkOutput("start_hp", boss_hp, 100);

    // Single melee pulse
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("melee_hp", boss_hp, 96);
    checkOutput("melee_flash", hit_flash, 1);
    checkOutput("melee_alive", boss_alive, 1);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);

    // Hits during i-frames do nothing
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("iframe_hp", boss_hp, 96);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    repeat (7) applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);
    checkOutput("iframe7_flash", hit_flash, 1);
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b1);
    checkOutput("iframe8_flash", hit_flash, 0);
    checkOutput("iframe8_hp", boss_hp, 96);
    checkOutput("iframe8_alive", boss_alive, 1);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("proj_hp", boss_hp, 94);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);

    // Simultaneous hits sum once
    applyStimulus(2'd1, 1'b1, 1'b1, 1'b0);
    checkOutput("both_hp", boss_hp, 88);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);

    // Held level is a single event, even after i-frames expire
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_first_hp", boss_hp, 84);
    repeat (8) applyStimulus(2'd1, 1'b1, 1'b0, 1'b1);
    repeat (91) applyStimulus(2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_hp", boss_hp, 84);
    checkOutput("hold_flash", hit_flash, 0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);

    // Whittle down to 2 HP, then a melee saturates to 0
    repeat (20) hitAndRecover(1'b1, 1'b0);
    checkOutput("low4_hp", boss_hp, 4);
    hitAndRecover(1'b0, 1'b1);
    checkOutput("low2_hp", boss_hp, 2);
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("lethal_hp", boss_hp, 0);
    checkOutput("lethal_alive", boss_alive, 0);
    checkOutput("lethal_dying", boss_dying, 1);
    checkOutput("lethal_flash", hit_flash, 0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'd1, 1'b1, 1'b1, 1'b0);
    checkOutput("dying_hit_hp", boss_hp, 0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    repeat (59) applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);
    checkOutput("dying59_dying", boss_dying, 1);
    checkOutput("dying59_defeated", boss_defeated, 0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);
    checkOutput("dead_defeated", boss_defeated, 1);
    checkOutput("dead_dying", boss_dying, 0);
    checkOutput("dead_alive", boss_alive, 0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("dead_pulse_end", boss_defeated, 0);
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("dead_hit_hp", boss_hp, 0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);

    // Leave the round, idle ignores hits
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_hp", boss_hp, 100);
    checkOutput("idle_alive", boss_alive, 0);
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_hit_hp", boss_hp, 100);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);

    // Abort while hurt with cnt=5
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_alive", boss_alive, 1);
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("restart_hit_hp", boss_hp, 96);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);
    checkOutput("cnt5_flash", hit_flash, 1);
    applyStimulus(2'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_hp", boss_hp, 100);
    checkOutput("abort_flash", hit_flash, 0);
    checkOutput("abort_alive", boss_alive, 0);
    checkOutput("abort_defeated", boss_defeated, 0);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_alive", boss_alive, 1);
    checkOutput("resume_hp", boss_hp, 100);

    // Exact-lethal hit (hp == dmg), then async reset mid-dying
    repeat (24) hitAndRecover(1'b1, 1'b0);
    checkOutput("exact4_hp", boss_hp, 4);
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("exact_hp", boss_hp, 0);
    checkOutput("exact_dying", boss_dying, 1);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b0);
    repeat (30) applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);
    frame_tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_hp", boss_hp, 100);
    checkOutput("async_dying", boss_dying, 0);
    checkOutput("async_alive", boss_alive, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_defeated", boss_defeated, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
